// File: rtl/mod_exp_ctrl_if.sv
// Job handshake between the exponentiation sequencer and mon_prod.
// master: sequencer side (drives jobs), slave: mon_prod side (reports completion).
interface mod_exp_ctrl_if #(
  parameter int LOG_BITLEN = 9
);
  logic                  mp_start;
  logic [1:0]            mp_op_code;
  logic [LOG_BITLEN:0]   mp_count;
  logic                  mp_stop;

  modport master (
    output mp_start,
    output mp_op_code,
    output mp_count,
    input  mp_stop
  );

  modport slave (
    input  mp_start,
    input  mp_op_code,
    input  mp_count,
    output mp_stop
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for x^E mod m on top of mon_prod.
// Issues one Montgomery job at a time (OPXX square, OPXM multiply, OPX1 final
// conversion) and waits for a fresh 0->1 completion on mp_stop before moving on.
// Optional build macro: SKIP_LZ_EN -- skip leading zero exponent bits in a SCAN
// state instead of spending a square on each of them.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; captures E and the clamped exp_len
// SCAN    | (SKIP_LZ_EN only) walk idx down past leading zero bits
// SQR_GO  | strobe an OPXX job
// SQR_WT  | wait for the square to complete, then pick the next job
// MUL_GO  | strobe an OPXM job
// MUL_WT  | wait for the multiply to complete
// FIN_GO  | strobe the OPX1 job that leaves the result at addr 0
// FIN_WT  | wait for the final job
// DONE    | one-cycle done pulse, back to IDLE
module mod_exp_ctrl #(
  parameter int BITLEN     = 512,
  parameter int LOG_BITLEN = 9,
  parameter int MP_COUNT   = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BITLEN-1:0]     E,
  input  logic [LOG_BITLEN:0]   exp_len,
  output logic                  busy,
  output logic                  done,
  output logic [LOG_BITLEN+2:0] op_cnt,
  mod_exp_ctrl_if.master        mp
);

  localparam logic [1:0] OP_XX = 2'd0;
  localparam logic [1:0] OP_XM = 2'd1;
  localparam logic [1:0] OP_X1 = 2'd2;

  localparam logic [LOG_BITLEN:0]   BITLEN_L = BITLEN[LOG_BITLEN:0];
  localparam logic [LOG_BITLEN:0]   ONE_L    = {{LOG_BITLEN{1'b0}}, 1'b1};
  localparam logic [LOG_BITLEN-1:0] ONE_I    = {{(LOG_BITLEN-1){1'b0}}, 1'b1};
  localparam logic [LOG_BITLEN+2:0] ONE_C    = {{(LOG_BITLEN+2){1'b0}}, 1'b1};
  localparam logic [LOG_BITLEN:0]   MP_CNT_L = MP_COUNT[LOG_BITLEN:0];

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef SKIP_LZ_EN
    S_SCAN,
`endif
    S_SQR_GO,
    S_SQR_WT,
    S_MUL_GO,
    S_MUL_WT,
    S_FIN_GO,
    S_FIN_WT,
    S_DONE
  } state_t;

  state_t                state;
  logic [BITLEN-1:0]     e_reg;
  logic [LOG_BITLEN-1:0] idx;
  logic                  armed;
  logic [LOG_BITLEN:0]   len_c;
  logic [LOG_BITLEN:0]   len_m1;

  // Exponent lengths beyond the register width are clamped.
  always_comb begin
    len_c  = (exp_len > BITLEN_L) ? BITLEN_L : exp_len;
    len_m1 = len_c - ONE_L;
  end

  assign mp.mp_count = MP_CNT_L;

  // Sequencer FSM with registered job strobe, op code, status and job counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      e_reg         <= '0;
      idx           <= '0;
      armed         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      op_cnt        <= '0;
      mp.mp_start   <= 1'b0;
      mp.mp_op_code <= OP_XX;
    end else begin
      mp.mp_start <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            e_reg  <= E;
            idx    <= len_m1[LOG_BITLEN-1:0];
            op_cnt <= '0;
            busy   <= 1'b1;
            if (len_c == '0) begin
              state <= S_FIN_GO;
            end else begin
`ifdef SKIP_LZ_EN
              state <= S_SCAN;
`else
              state <= S_SQR_GO;
`endif
            end
          end
        end
`ifdef SKIP_LZ_EN
        S_SCAN: begin
          if (e_reg[idx]) begin
            state <= S_SQR_GO;
          end else if (idx == '0) begin
            state <= S_FIN_GO;
          end else begin
            idx <= idx - ONE_I;
          end
        end
`endif
        S_SQR_GO: begin
          mp.mp_start   <= 1'b1;
          mp.mp_op_code <= OP_XX;
          op_cnt        <= op_cnt + ONE_C;
          armed         <= 1'b0;
          state         <= S_SQR_WT;
        end
        S_SQR_WT: begin
          // A stop level still high from the previous job must not count.
          if (!mp.mp_stop) begin
            armed <= 1'b1;
          end else if (armed) begin
            if (e_reg[idx]) begin
              state <= S_MUL_GO;
            end else if (idx == '0) begin
              state <= S_FIN_GO;
            end else begin
              idx   <= idx - ONE_I;
              state <= S_SQR_GO;
            end
          end
        end
        S_MUL_GO: begin
          mp.mp_start   <= 1'b1;
          mp.mp_op_code <= OP_XM;
          op_cnt        <= op_cnt + ONE_C;
          armed         <= 1'b0;
          state         <= S_MUL_WT;
        end
        S_MUL_WT: begin
          if (!mp.mp_stop) begin
            armed <= 1'b1;
          end else if (armed) begin
            if (idx == '0) begin
              state <= S_FIN_GO;
            end else begin
              idx   <= idx - ONE_I;
              state <= S_SQR_GO;
            end
          end
        end
        S_FIN_GO: begin
          mp.mp_start   <= 1'b1;
          mp.mp_op_code <= OP_X1;
          op_cnt        <= op_cnt + ONE_C;
          armed         <= 1'b0;
          state         <= S_FIN_WT;
        end
        S_FIN_WT: begin
          if (!mp.mp_stop) begin
            armed <= 1'b1;
          end else if (armed) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural mon_prod plus an op-code scoreboard.
module tb_mod_exp_ctrl;

  localparam int BL  = 16;
  localparam int LBL = 4;
  localparam int N   = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [BL-1:0]  e_in;
  logic [LBL:0]   exp_len;
  logic           busy;
  logic           done;
  logic [LBL+2:0] op_cnt;

  mod_exp_ctrl_if #(.LOG_BITLEN(LBL)) mp_bus ();

  mod_exp_ctrl #(.BITLEN(BL), .LOG_BITLEN(LBL), .MP_COUNT(BL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .E       (e_in),
    .exp_len (exp_len),
    .busy    (busy),
    .done    (done),
    .op_cnt  (op_cnt),
    .mp      (mp_bus.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];
  int mp_t   = 0;
  bit glitch = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Behavioural mon_prod: stop drops one cycle after start (two with glitch), rises N cycles later.
  always @(negedge clk) begin
    int g;
    g = glitch ? 1 : 0;
    if (mp_bus.mp_start === 1'b1) begin
      chk("job_overlap", mp_t, 0);
      if (exp_q.size() == 0) chk("unexpected_job", 1, 0);
      else chk("op_code", {30'd0, mp_bus.mp_op_code}, exp_q.pop_front());
      chk("mp_count", {27'd0, mp_bus.mp_count}, BL);
      mp_t = 1;
    end else if (mp_t > 0) begin
      mp_t++;
    end
    if (mp_t > N + g) mp_t = 0;
    mp_bus.mp_stop = !(mp_t >= 1 + g && mp_t <= N + g);
  end

  // Reference sequence of op codes for one run; returns the job count.
  task automatic push_ops(input logic [BL-1:0] e, input int len, output int n_ops);
    int l;
    int i;
    l = (len > BL) ? BL : len;
    i = l - 1;
`ifdef SKIP_LZ_EN
    while (i > 0 && !e[i]) i--;
    if (l > 0 && !e[i]) i = -1;
`endif
    n_ops = 0;
    for (int j = i; j >= 0; j--) begin
      exp_q.push_back(0); n_ops++;
      if (e[j]) begin exp_q.push_back(1); n_ops++; end
    end
    exp_q.push_back(2); n_ops++;
  endtask

  task automatic run_job(input logic [BL-1:0] e, input int len, input bit g, input bit poke);
    int n_ops;
    int cyc;
    glitch = g;
    push_ops(e, len, n_ops);
    @(negedge clk);
    e_in = e; exp_len = len[LBL:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 7) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk("done_timeout", {31'd0, cyc < 5000}, 1);
    chk("op_cnt", {25'd0, op_cnt}, n_ops);
    chk("busy_at_done", {31'd0, busy}, 0);
    chk("leftover_ops", exp_q.size(), 0);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_width", {31'd0, done}, 0);
    repeat (3) @(negedge clk);
    chk("idle_after_done", {31'd0, busy}, 0);
    chk("op_cnt_hold", {25'd0, op_cnt}, n_ops);
    exp_q.delete();
    glitch = 1'b0;
  endtask

  initial begin
    int cyc;
    int n_ops;
    rst_n = 1'b0; start = 1'b0; e_in = '0; exp_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_op_cnt", {25'd0, op_cnt}, 0);
    chk("rst_mp_start", {31'd0, mp_bus.mp_start}, 0);
    chk("rst_op_code", {30'd0, mp_bus.mp_op_code}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(16'h000b, 4, 1'b0, 1'b0);
    chk("t1_op_cnt_8", {25'd0, op_cnt}, 8);
    run_job(16'h1234, 0, 1'b0, 1'b0);
    chk("t2_op_cnt_1", {25'd0, op_cnt}, 1);
    run_job(16'h000b, 4, 1'b1, 1'b0);
    run_job(16'h000b, 4, 1'b0, 1'b1);
    chk("t4_op_cnt_8", {25'd0, op_cnt}, 8);

    // Reset while waiting on a multiply.
    push_ops(16'h000b, 4, n_ops);
    @(negedge clk);
    e_in = 16'h000b; exp_len = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mp_bus.mp_op_code == 2'd1 && mp_bus.mp_start == 1'b0 && busy) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_mul_wt", {31'd0, cyc < 1000}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_mp_start", {31'd0, mp_bus.mp_start}, 0);
    chk("rst_mid_op_cnt", {25'd0, op_cnt}, 0);
    chk("rst_mid_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    exp_q.delete();
    cyc = 0;
    while (mp_t != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("mp_drain", {31'd0, cyc < 100}, 1);
    @(negedge clk);
    run_job(16'h0001, 1, 1'b0, 1'b0);
    chk("t5_op_cnt_3", {25'd0, op_cnt}, 3);

    run_job(16'h0002, 4, 1'b0, 1'b0);
`ifdef SKIP_LZ_EN
    chk("t6_op_cnt", {25'd0, op_cnt}, 4);
`else
    chk("t6_op_cnt", {25'd0, op_cnt}, 6);
`endif

    run_job(16'hfff5, 4, 1'b0, 1'b0);
    run_job(16'ha5c3, 20, 1'b0, 1'b0);
    run_job(16'h0000, 16, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_job(16'($urandom), int'($urandom_range(1, 16)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
